// File: rtl/mrt_poly_normalize_if.sv
// Handshake bundle between the polynomial producer and mrt_poly_normalize.
// master = producer/consumer side, slave = the normalizer.
interface mrt_poly_normalize_if #(
    parameter int unsigned NUM_COEFFS = 20,
    parameter int unsigned WORD_BITS  = 16,
    parameter int unsigned COEFF_BITS = 17
);
    localparam int unsigned OUT_BITS  = NUM_COEFFS * WORD_BITS;
    localparam int unsigned POLY_BITS = NUM_COEFFS * COEFF_BITS;

    logic                 in_valid_i;
    logic                 in_ready_o;
    logic [POLY_BITS-1:0] poly_i;
    logic                 out_valid_o;
    logic                 out_ready_i;
    logic [OUT_BITS-1:0]  int_o;
    logic                 overflow_o;

    modport master (
        output in_valid_i, poly_i, out_ready_i,
        input  in_ready_o, out_valid_o, int_o, overflow_o
    );

    modport slave (
        input  in_valid_i, poly_i, out_ready_i,
        output in_ready_o, out_valid_o, int_o, overflow_o
    );
endinterface

// File: rtl/mrt_poly_normalize.sv
// Serial carry resolver: redundant-form polynomial -> canonical packed integer.
// Define MRT_POLY_NORMALIZE_REDUCE_EN to add one conditional subtraction of MODULUS.
module mrt_poly_normalize #(
    parameter int unsigned NUM_COEFFS = 20,
    parameter int unsigned WORD_BITS  = 16,
    parameter int unsigned COEFF_BITS = 17
`ifdef MRT_POLY_NORMALIZE_REDUCE_EN
    ,
    parameter logic [NUM_COEFFS*WORD_BITS-1:0] MODULUS =
        {(NUM_COEFFS*WORD_BITS){1'b1}} - (NUM_COEFFS*WORD_BITS)'(188)
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mrt_poly_normalize_if.slave  bus,
    output logic                 busy_o
);
    localparam int unsigned OUT_BITS   = NUM_COEFFS * WORD_BITS;
    localparam int unsigned POLY_BITS  = NUM_COEFFS * COEFF_BITS;
    localparam int unsigned SUM_BITS   = COEFF_BITS + 1;
    localparam int unsigned CARRY_BITS = COEFF_BITS - WORD_BITS + 1;
    localparam int unsigned IDX_BITS   = $clog2(NUM_COEFFS);
    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NUM_COEFFS - 1);

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
`ifdef MRT_POLY_NORMALIZE_REDUCE_EN
        ,
        REDUCE
`endif
    } state_t;

    state_t                state;
    logic [POLY_BITS-1:0]  poly_q;
    logic [IDX_BITS-1:0]   idx;
    logic [CARRY_BITS-1:0] carry;

    logic [COEFF_BITS-1:0] coeff_c;
    logic [SUM_BITS-1:0]   sum_c;
    logic [CARRY_BITS-1:0] carry_c;

    // Current coefficient plus incoming carry; sum is wide enough never to truncate.
    always_comb begin
        coeff_c = poly_q[32'(idx) * COEFF_BITS +: COEFF_BITS];
        sum_c   = SUM_BITS'(coeff_c) + SUM_BITS'(carry);
        carry_c = sum_c[SUM_BITS-1:WORD_BITS];
    end

`ifdef MRT_POLY_NORMALIZE_REDUCE_EN
    localparam int unsigned DIFF_BITS = WORD_BITS + 1;

    logic [OUT_BITS-1:0]  shadow;
    logic                 borrow;
    logic [DIFF_BITS-1:0] diff_c;

    // Word-serial subtraction of MODULUS from the resolved result; top bit is the borrow out.
    always_comb begin
        diff_c = {1'b0, bus.int_o[32'(idx) * WORD_BITS +: WORD_BITS]}
               - {1'b0, MODULUS[32'(idx) * WORD_BITS +: WORD_BITS]}
               - DIFF_BITS'(borrow);
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            poly_q          <= '0;
            idx             <= '0;
            carry           <= '0;
            bus.in_ready_o  <= 1'b1;
            bus.out_valid_o <= 1'b0;
            bus.int_o       <= '0;
            bus.overflow_o  <= 1'b0;
            busy_o          <= 1'b0;
`ifdef MRT_POLY_NORMALIZE_REDUCE_EN
            shadow          <= '0;
            borrow          <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid_i && bus.in_ready_o) begin
                        poly_q         <= bus.poly_i;
                        carry          <= '0;
                        idx            <= '0;
                        bus.in_ready_o <= 1'b0;
                        busy_o         <= 1'b1;
                        state          <= CONV;
                    end
                end
                CONV: begin
                    bus.int_o[32'(idx) * WORD_BITS +: WORD_BITS] <= sum_c[WORD_BITS-1:0];
                    carry <= carry_c;
                    if (idx == LAST_IDX) begin
                        bus.overflow_o <= (carry_c != '0);
                        idx            <= '0;
`ifdef MRT_POLY_NORMALIZE_REDUCE_EN
                        borrow         <= 1'b0;
                        state          <= REDUCE;
`else
                        bus.out_valid_o <= 1'b1;
                        state           <= DONE;
`endif
                    end else begin
                        idx <= idx + IDX_BITS'(1);
                    end
                end
`ifdef MRT_POLY_NORMALIZE_REDUCE_EN
                REDUCE: begin
                    // Shadow fills from the top so it is aligned after the last word.
                    shadow <= {diff_c[WORD_BITS-1:0], shadow[OUT_BITS-1:WORD_BITS]};
                    borrow <= diff_c[WORD_BITS];
                    if (idx == LAST_IDX) begin
                        if (bus.overflow_o || !diff_c[WORD_BITS]) begin
                            bus.int_o      <= {diff_c[WORD_BITS-1:0], shadow[OUT_BITS-1:WORD_BITS]};
                            bus.overflow_o <= 1'b0;
                        end
                        idx             <= '0;
                        bus.out_valid_o <= 1'b1;
                        state           <= DONE;
                    end else begin
                        idx <= idx + IDX_BITS'(1);
                    end
                end
`endif
                DONE: begin
                    if (bus.out_valid_o && bus.out_ready_i) begin
                        bus.out_valid_o <= 1'b0;
                        bus.in_ready_o  <= 1'b1;
                        busy_o          <= 1'b0;
                        state           <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
